// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr
//  Purpose  : N:1 valid/ready streaming multiplexer. It picks one input
//             channel per cycle, either by round-robin arbitration or by a
//             fixed select. The winning word and its channel index go into a
//             single output register stage.
//  Ports    : clk, rst       - clock (rising edge), synchronous active-high
//                              reset
//             in_data        - N packed channels, channel i at [i*WIDTH +: WIDTH]
//             in_valid       - per-channel valid
//             in_ready       - per-channel ready (combinational, one-hot/zero)
//             mode           - 0 = round-robin, 1 = fixed select
//             fix_sel        - channel used when mode = 1
//             out_data       - registered output word
//             out_chan       - registered source channel index
//             out_valid      - output register holds a word
//             out_ready      - downstream accepts the word
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_rr #(
   parameter int WIDTH = 8,
   parameter int N     = 8,
   parameter int SELW  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      fix_sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SELW-1:0]  r_ptr;
   logic             w_load_en;
   logic [N-1:0]     w_grant;
   logic             w_any;
   logic [SELW-1:0]  w_idx;
   logic [WIDTH-1:0] w_word;

   // The output register can take a new word when it is empty or being
   // drained this cycle; this gives the out_ready -> in_ready path.
   assign w_load_en = !out_valid || out_ready;

   // Grant selection. Round-robin walks positions ptr, ptr+1, ... (mod N)
   // and takes the first valid one. Fixed mode grants nothing when fix_sel
   // names no existing channel, because no loop index matches it.
   always_comb begin : p_grant
      logic [SELW:0] pos;
      logic          found;
      w_grant = '0;
      pos     = '0;
      found   = 1'b0;
      if (!mode) begin
         for (int k = 0; k < N; k++) begin
            pos = {1'b0, r_ptr} + (SELW+1)'(k);
            if (pos >= (SELW+1)'(N)) begin
               pos = pos - (SELW+1)'(N);
            end
            for (int i = 0; i < N; i++) begin
               if (!found && pos == (SELW+1)'(i) && in_valid[i]) begin
                  w_grant[i] = 1'b1;
                  found      = 1'b1;
               end
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (fix_sel == SELW'(i) && in_valid[i]) begin
               w_grant[i] = 1'b1;
            end
         end
      end
   end

   // Encode the one-hot grant into an index and select the matching word.
   always_comb begin : p_select
      w_idx  = '0;
      w_word = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant[i]) begin
            w_idx  = SELW'(i);
            w_word = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_any    = |w_grant;
   assign in_ready = (rst || !w_load_en) ? '0 : w_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         r_ptr     <= '0;
      end else if (w_load_en) begin
         if (w_any) begin
            out_valid <= 1'b1;
            out_data  <= w_word;
            out_chan  <= w_idx;
            // Fixed-select transfers leave the round-robin position alone.
            if (!mode) begin
               r_ptr <= (w_idx == SELW'(N-1)) ? '0 : w_idx + SELW'(1);
            end
         end else begin
            // Word drained (or none held) and nothing to load: go empty but
            // keep the last data/channel visible.
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
